// File: rtl/decode_stage_if.sv
// Bundle between the decode stage and its neighbours: fetch, register-file read
// and write-back snoop ports, and the execute-side payload.
interface decode_stage_if;
    // Handshakes: a word moves on a rising edge where valid && ready; the sender
    // holds valid and payload stable until then, and ready may depend on valid.
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  reg_1_select;
    logic [4:0]  reg_2_select;
    logic [31:0] reg_1;
    logic [31:0] reg_2;
    logic        wb_en;
    logic [4:0]  wb_select;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  out_rd;
    logic [31:0] out_rs1_val;
    logic [31:0] out_rs2_val;
    logic [31:0] out_imm;
    logic [3:0]  out_op;
    logic [2:0]  out_funct3;
    logic        out_funct7b5;
    logic        out_illegal;

    modport slave (
        input  flush, in_valid, in_instr, in_pc, reg_1, reg_2,
        input  wb_en, wb_select, wb_data, out_ready,
        output in_ready, reg_1_select, reg_2_select, out_valid,
        output out_pc, out_rd, out_rs1_val, out_rs2_val, out_imm,
        output out_op, out_funct3, out_funct7b5, out_illegal
    );

    modport master (
        output flush, in_valid, in_instr, in_pc, reg_1, reg_2,
        output wb_en, wb_select, wb_data, out_ready,
        input  in_ready, reg_1_select, reg_2_select, out_valid,
        input  out_pc, out_rd, out_rs1_val, out_rs2_val, out_imm,
        input  out_op, out_funct3, out_funct7b5, out_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: slot A waits one cycle for register-file read data,
// slot O is the execute-facing output register.
module decode_stage (
    input  logic           clock,
    input  logic           reset_n,
    decode_stage_if.slave  bus
);
    typedef enum logic [3:0] {
        OP_ILLEGAL = 4'd0,
        OP_LUI     = 4'd1,
        OP_AUIPC   = 4'd2,
        OP_JAL     = 4'd3,
        OP_JALR    = 4'd4,
        OP_BRANCH  = 4'd5,
        OP_LOAD    = 4'd6,
        OP_STORE   = 4'd7,
        OP_OPIMM   = 4'd8,
        OP_OP      = 4'd9,
        OP_FENCE   = 4'd10,
        OP_SYSTEM  = 4'd11
    } op_e;

    logic        r_a_valid;
    logic [31:0] r_a_instr;
    logic [31:0] r_a_pc;
    logic        r_a_byp1;
    logic        r_a_byp2;
    logic [31:0] r_a_byp1_data;
    logic [31:0] r_a_byp2_data;

    logic        r_o_valid;
    logic [31:0] r_o_pc;
    logic [4:0]  r_o_rd;
    logic [31:0] r_o_rs1_val;
    logic [31:0] r_o_rs2_val;
    logic [31:0] r_o_imm;
    logic [3:0]  r_o_op;
    logic [2:0]  r_o_funct3;
    logic        r_o_funct7b5;
    logic        r_o_illegal;

    logic        w_a_move;
    logic        w_in_ready;
    logic        w_accept;
    logic        w_sel_from_in;
    logic [4:0]  w_rs1_in;
    logic [4:0]  w_rs2_in;
    logic [4:0]  w_rs1_a;
    logic [4:0]  w_rs2_a;
    logic        w_hit1_in;
    logic        w_hit2_in;
    logic        w_hit1_a;
    logic        w_hit2_a;
    logic [31:0] w_rs1_val;
    logic [31:0] w_rs2_val;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    op_e         w_op;
    logic [31:0] w_imm;
    logic [4:0]  w_rd;
    logic        w_funct7b5;

    assign w_a_move   = r_a_valid && (!r_o_valid || bus.out_ready);
    assign w_in_ready = !r_a_valid || w_a_move;
    assign w_accept   = bus.in_valid && w_in_ready && !bus.flush;

    assign w_rs1_in = bus.in_instr[19:15];
    assign w_rs2_in = bus.in_instr[24:20];
    assign w_rs1_a  = r_a_instr[19:15];
    assign w_rs2_a  = r_a_instr[24:20];

    // A held instruction keeps re-reading its own operands every cycle.
    assign w_sel_from_in    = !r_a_valid || w_a_move;
    assign bus.reg_1_select = w_sel_from_in ? w_rs1_in : w_rs1_a;
    assign bus.reg_2_select = w_sel_from_in ? w_rs2_in : w_rs2_a;

    assign w_hit1_in = bus.wb_en && (bus.wb_select == w_rs1_in) && (w_rs1_in != 5'd0);
    assign w_hit2_in = bus.wb_en && (bus.wb_select == w_rs2_in) && (w_rs2_in != 5'd0);
    assign w_hit1_a  = bus.wb_en && (bus.wb_select == w_rs1_a)  && (w_rs1_a  != 5'd0);
    assign w_hit2_a  = bus.wb_en && (bus.wb_select == w_rs2_a)  && (w_rs2_a  != 5'd0);

    assign w_imm_i = {{20{r_a_instr[31]}}, r_a_instr[31:20]};
    assign w_imm_s = {{20{r_a_instr[31]}}, r_a_instr[31:25], r_a_instr[11:7]};
    assign w_imm_b = {{19{r_a_instr[31]}}, r_a_instr[31], r_a_instr[7],
                      r_a_instr[30:25], r_a_instr[11:8], 1'b0};
    assign w_imm_u = {r_a_instr[31:12], 12'd0};
    assign w_imm_j = {{11{r_a_instr[31]}}, r_a_instr[31], r_a_instr[19:12],
                      r_a_instr[20], r_a_instr[30:21], 1'b0};

    // Every legal opcode ends in 2'b11, so the low-bit check falls out of the default.
    always_comb begin
        w_op  = OP_ILLEGAL;
        w_imm = 32'd0;
        case (r_a_instr[6:0])
            7'b0110111: begin w_op = OP_LUI;    w_imm = w_imm_u; end
            7'b0010111: begin w_op = OP_AUIPC;  w_imm = w_imm_u; end
            7'b1101111: begin w_op = OP_JAL;    w_imm = w_imm_j; end
            7'b1100111: begin w_op = OP_JALR;   w_imm = w_imm_i; end
            7'b1100011: begin w_op = OP_BRANCH; w_imm = w_imm_b; end
            7'b0000011: begin w_op = OP_LOAD;   w_imm = w_imm_i; end
            7'b0100011: begin w_op = OP_STORE;  w_imm = w_imm_s; end
            7'b0010011: begin w_op = OP_OPIMM;  w_imm = w_imm_i; end
            7'b0110011: begin w_op = OP_OP;     w_imm = 32'd0;   end
            7'b0001111: begin w_op = OP_FENCE;  w_imm = 32'd0;   end
            7'b1110011: begin w_op = OP_SYSTEM; w_imm = w_imm_i; end
            default:    begin w_op = OP_ILLEGAL; w_imm = 32'd0;  end
        endcase
    end

    assign w_rd = (w_op inside {OP_BRANCH, OP_STORE, OP_FENCE, OP_ILLEGAL}) ?
                  5'd0 : r_a_instr[11:7];
    assign w_funct7b5 = r_a_instr[30] &&
                        ((w_op == OP_OP) || ((w_op == OP_OPIMM) && (r_a_instr[14:12] == 3'b101)));

    assign w_rs1_val = (w_rs1_a == 5'd0) ? 32'd0 : (r_a_byp1 ? r_a_byp1_data : bus.reg_1);
    assign w_rs2_val = (w_rs2_a == 5'd0) ? 32'd0 : (r_a_byp2 ? r_a_byp2_data : bus.reg_2);

    // Slot A: the bypass latch covers writes the register file read may have missed.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_a_valid     <= 1'b0;
            r_a_instr     <= 32'd0;
            r_a_pc        <= 32'd0;
            r_a_byp1      <= 1'b0;
            r_a_byp2      <= 1'b0;
            r_a_byp1_data <= 32'd0;
            r_a_byp2_data <= 32'd0;
        end else if (bus.flush) begin
            r_a_valid <= 1'b0;
        end else if (w_accept) begin
            r_a_valid <= 1'b1;
            r_a_instr <= bus.in_instr;
            r_a_pc    <= bus.in_pc;
            r_a_byp1  <= w_hit1_in;
            r_a_byp2  <= w_hit2_in;
            if (w_hit1_in) r_a_byp1_data <= bus.wb_data;
            if (w_hit2_in) r_a_byp2_data <= bus.wb_data;
        end else if (w_a_move) begin
            r_a_valid <= 1'b0;
        end else if (r_a_valid) begin
            if (w_hit1_a) begin
                r_a_byp1      <= 1'b1;
                r_a_byp1_data <= bus.wb_data;
            end
            if (w_hit2_a) begin
                r_a_byp2      <= 1'b1;
                r_a_byp2_data <= bus.wb_data;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_o_valid    <= 1'b0;
            r_o_pc       <= 32'd0;
            r_o_rd       <= 5'd0;
            r_o_rs1_val  <= 32'd0;
            r_o_rs2_val  <= 32'd0;
            r_o_imm      <= 32'd0;
            r_o_op       <= 4'd0;
            r_o_funct3   <= 3'd0;
            r_o_funct7b5 <= 1'b0;
            r_o_illegal  <= 1'b0;
        end else if (bus.flush) begin
            r_o_valid <= 1'b0;
        end else if (w_a_move) begin
            r_o_valid    <= 1'b1;
            r_o_pc       <= r_a_pc;
            r_o_rd       <= w_rd;
            r_o_rs1_val  <= w_rs1_val;
            r_o_rs2_val  <= w_rs2_val;
            r_o_imm      <= w_imm;
            r_o_op       <= w_op;
            r_o_funct3   <= r_a_instr[14:12];
            r_o_funct7b5 <= w_funct7b5;
            r_o_illegal  <= (w_op == OP_ILLEGAL);
        end else if (bus.out_ready) begin
            r_o_valid <= 1'b0;
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = r_o_valid;
    assign bus.out_pc       = r_o_pc;
    assign bus.out_rd       = r_o_rd;
    assign bus.out_rs1_val  = r_o_rs1_val;
    assign bus.out_rs2_val  = r_o_rs2_val;
    assign bus.out_imm      = r_o_imm;
    assign bus.out_op       = r_o_op;
    assign bus.out_funct3   = r_o_funct3;
    assign bus.out_funct7b5 = r_o_funct7b5;
    assign bus.out_illegal  = r_o_illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a register-file model feeds reads, expected
// execute payloads are queued on acceptance and checked on each output transfer.
module tb_decode_stage;
    localparam int PW = 142;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [3:0]  op;
        logic [2:0]  f3;
        logic        f7b5;
        logic        ill;
    } exp_t;

    logic           clock;
    logic           reset_n;
    logic           rf_clear;
    logic [31:0]    rf [32];
    logic [PW-1:0]  exp_q [$];
    exp_t           cur_exp;
    exp_t           e1, e2, e3, e4;
    logic [31:0]    s2_instr [6];
    exp_t           s2_exp [6];
    int             n_vec;
    int             n_err;

    decode_stage_if dif ();

    decode_stage dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (dif)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Register file with 1-cycle read latency; a same-edge write is not visible to the read.
    always @(posedge clock) begin
        if (rf_clear) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
        end else if (dif.wb_en) begin
            rf[dif.wb_select] <= dif.wb_data;
        end
        dif.reg_1 <= rf[dif.reg_1_select];
        dif.reg_2 <= rf[dif.reg_2_select];
    end

    function automatic exp_t mk(input logic [31:0] pc, input logic [4:0] rd,
                                input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [31:0] imm, input logic [3:0] op,
                                input logic [2:0] f3, input logic f7b5, input logic ill);
        exp_t e;
        e.pc = pc; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm;
        e.op = op; e.f3 = f3; e.f7b5 = f7b5; e.ill = ill;
        return e;
    endfunction

    function automatic logic [PW-1:0] obs_payload();
        return {dif.out_pc, dif.out_rd, dif.out_rs1_val, dif.out_rs2_val, dif.out_imm,
                dif.out_op, dif.out_funct3, dif.out_funct7b5, dif.out_illegal};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_vec++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic chk_p(input string tag, input logic [PW-1:0] o, input logic [PW-1:0] e);
        n_vec++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    // One clock: score the transfers the coming edge will perform, then cross it.
    task automatic step();
        logic [PW-1:0] e;
        #1;
        if (dif.out_valid && dif.out_ready && !dif.flush) begin
            chk("out_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk_p("out_payload", obs_payload(), e);
            end
        end
        if (dif.in_valid && dif.in_ready && !dif.flush) exp_q.push_back(cur_exp);
        if (dif.flush) exp_q.delete();
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        dif.out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_idle", 32'(dif.out_valid), 32'd0);
    endtask

    task automatic wb_write(input logic [4:0] sel, input logic [31:0] data);
        dif.wb_en     = 1'b1;
        dif.wb_select = sel;
        dif.wb_data   = data;
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        reset_n       = 1'b0;
        rf_clear      = 1'b1;
        dif.flush     = 1'b0;
        dif.in_valid  = 1'b0;
        dif.in_instr  = 32'h00528333;
        dif.in_pc     = 32'd0;
        dif.wb_en     = 1'b0;
        dif.wb_select = 5'd0;
        dif.wb_data   = 32'd0;
        dif.out_ready = 1'b1;
        cur_exp       = '0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        chk_p("rst_payload", obs_payload(), '0);
        chk("rst_out_valid", 32'(dif.out_valid), 32'd0);
        chk("rst_in_ready", 32'(dif.in_ready), 32'd1);
        chk("rst_sel1", 32'(dif.reg_1_select), 32'd5);
        dif.in_instr = 32'h00400693;
        #1;
        chk("rst_sel2", 32'(dif.reg_2_select), 32'd4);
        rf_clear = 1'b0;
        reset_n  = 1'b1;

        // Preload x5=7, x1=0x11, x2=0x22, x7=0x77
        wb_write(5'd5, 32'h7);  step();
        wb_write(5'd1, 32'h11); step();
        wb_write(5'd2, 32'h22); step();
        wb_write(5'd7, 32'h77); step();
        dif.wb_en = 1'b0;

        // Scenario 1: addi x1,x0,5 and its latency
        dif.in_valid = 1'b1;
        dif.in_instr = 32'h00500093;
        dif.in_pc    = 32'h100;
        cur_exp      = mk(32'h100, 5'd1, 32'h0, 32'h7, 32'h5, 4'd8, 3'd0, 1'b0, 1'b0);
        step();
        dif.in_valid = 1'b0;
        chk("s1_lat_edge_n", 32'(dif.out_valid), 32'd0);
        step();
        chk("s1_lat_edge_n1", 32'(dif.out_valid), 32'd1);
        drain();

        // Scenario 2: immediate formats, back-to-back at full rate
        s2_instr[0] = 32'hFE000EE3; s2_exp[0] = mk(32'h200, 5'd0, 32'h0,  32'h0,  32'hFFFFFFFC, 4'd5, 3'd0, 1'b0, 1'b0);
        s2_instr[1] = 32'hFE20AA23; s2_exp[1] = mk(32'h204, 5'd0, 32'h11, 32'h22, 32'hFFFFFFF4, 4'd7, 3'd2, 1'b0, 1'b0);
        s2_instr[2] = 32'h123451B7; s2_exp[2] = mk(32'h208, 5'd3, 32'h0,  32'h0,  32'h12345000, 4'd1, 3'd5, 1'b0, 1'b0);
        s2_instr[3] = 32'h801FF0EF; s2_exp[3] = mk(32'h20C, 5'd1, 32'h0,  32'h11, 32'hFFFFF800, 4'd3, 3'd7, 1'b0, 1'b0);
        s2_instr[4] = 32'h402083B3; s2_exp[4] = mk(32'h210, 5'd7, 32'h11, 32'h22, 32'h0,        4'd9, 3'd0, 1'b1, 1'b0);
        s2_instr[5] = 32'h4030D213; s2_exp[5] = mk(32'h214, 5'd4, 32'h11, 32'h0,  32'h403,      4'd8, 3'd5, 1'b1, 1'b0);
        dif.in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            dif.in_instr = s2_instr[i];
            dif.in_pc    = s2_exp[i].pc;
            cur_exp      = s2_exp[i];
            chk("s2_in_ready", 32'(dif.in_ready), 32'd1);
            step();
        end
        dif.in_valid = 1'b0;
        drain();

        // Scenario 3: same-edge write bypass, then a write to x0 that must not bypass
        dif.in_valid = 1'b1;
        dif.in_instr = 32'h00528333;
        dif.in_pc    = 32'h300;
        cur_exp      = mk(32'h300, 5'd6, 32'h99, 32'h99, 32'h0, 4'd9, 3'd0, 1'b0, 1'b0);
        wb_write(5'd5, 32'h99);
        step();
        dif.in_instr = 32'h00000433;
        dif.in_pc    = 32'h304;
        cur_exp      = mk(32'h304, 5'd8, 32'h0, 32'h0, 32'h0, 4'd9, 3'd0, 1'b0, 1'b0);
        wb_write(5'd0, 32'hDEAD);
        step();
        dif.wb_en    = 1'b0;
        dif.in_valid = 1'b0;
        drain();

        // Scenario 4: backpressure with a write to a held operand
        e1 = mk(32'h400, 5'd10, 32'h11,  32'h11,  32'h1, 4'd8, 3'd0, 1'b0, 1'b0);
        e2 = mk(32'h404, 5'd11, 32'h2A2, 32'h2A2, 32'h2, 4'd8, 3'd0, 1'b0, 1'b0);
        e3 = mk(32'h408, 5'd12, 32'h77,  32'h0,   32'h3, 4'd8, 3'd0, 1'b0, 1'b0);
        e4 = mk(32'h40C, 5'd13, 32'h0,   32'h0,   32'h4, 4'd8, 3'd0, 1'b0, 1'b0);
        dif.out_ready = 1'b0;
        dif.in_valid  = 1'b1;
        dif.in_instr = 32'h00108513; dif.in_pc = e1.pc; cur_exp = e1; step();
        dif.in_instr = 32'h00210593; dif.in_pc = e2.pc; cur_exp = e2; step();
        dif.in_instr = 32'h00338613; dif.in_pc = e3.pc; cur_exp = e3;
        chk("s4_full_in_ready", 32'(dif.in_ready), 32'd0);
        chk("s4_full_out_valid", 32'(dif.out_valid), 32'd1);
        step();
        chk_p("s4_hold0", obs_payload(), e1);
        wb_write(5'd2, 32'h2A2);
        step();
        dif.wb_en = 1'b0;
        chk_p("s4_hold1", obs_payload(), e1);
        step();
        chk_p("s4_hold2", obs_payload(), e1);
        chk("s4_hold_in_ready", 32'(dif.in_ready), 32'd0);
        dif.out_ready = 1'b1;
        step();
        dif.in_instr = 32'h00400693; dif.in_pc = e4.pc; cur_exp = e4; step();
        dif.in_valid = 1'b0;
        drain();

        // Scenario 5a: flush with both slots full and a pending fetch
        dif.out_ready = 1'b0;
        dif.in_valid  = 1'b1;
        dif.in_instr = 32'h00108513; dif.in_pc = 32'h500; cur_exp = e1; step();
        dif.in_instr = 32'h00210593; dif.in_pc = 32'h504; cur_exp = e2; step();
        chk("s5_full_out_valid", 32'(dif.out_valid), 32'd1);
        dif.in_instr  = 32'h00338613;
        dif.in_pc     = 32'h508;
        cur_exp       = e3;
        dif.out_ready = 1'b1;
        dif.flush     = 1'b1;
        step();
        dif.flush    = 1'b0;
        dif.in_valid = 1'b0;
        chk("s5_flush_out_valid", 32'(dif.out_valid), 32'd0);
        step();
        chk("s5_after_flush_out_valid", 32'(dif.out_valid), 32'd0);
        chk("s5_after_flush_in_ready", 32'(dif.in_ready), 32'd1);

        // Scenario 5b: asynchronous reset in the middle of a stall
        dif.out_ready = 1'b0;
        dif.in_valid  = 1'b1;
        dif.in_instr = 32'h00108513; dif.in_pc = 32'h520; cur_exp = e1; step();
        dif.in_instr = 32'h00210593; dif.in_pc = 32'h524; cur_exp = e2; step();
        dif.in_instr = 32'h00338613;
        #2;
        reset_n = 1'b0;
        #1;
        chk("s5_rst_out_valid", 32'(dif.out_valid), 32'd0);
        chk_p("s5_rst_payload", obs_payload(), '0);
        chk("s5_rst_in_ready", 32'(dif.in_ready), 32'd1);
        chk("s5_rst_sel1", 32'(dif.reg_1_select), 32'd7);
        chk("s5_rst_sel2", 32'(dif.reg_2_select), 32'd3);
        exp_q.delete();
        dif.in_valid = 1'b0;
        @(posedge clock);
        #3;
        reset_n       = 1'b1;
        dif.out_ready = 1'b1;
        dif.in_valid  = 1'b1;
        dif.in_instr  = 32'h00500093;
        dif.in_pc     = 32'h600;
        cur_exp       = mk(32'h600, 5'd1, 32'h0, 32'h99, 32'h5, 4'd8, 3'd0, 1'b0, 1'b0);
        step();
        dif.in_valid = 1'b0;
        chk("s5_post_rst_edge_n", 32'(dif.out_valid), 32'd0);
        step();
        chk("s5_post_rst_edge_n1", 32'(dif.out_valid), 32'd1);
        drain();

        // Scenario 6: illegal encodings
        dif.in_valid = 1'b1;
        dif.in_instr = 32'h00000000;
        dif.in_pc    = 32'h700;
        cur_exp      = mk(32'h700, 5'd0, 32'h0, 32'h0, 32'h0, 4'd0, 3'd0, 1'b0, 1'b1);
        step();
        dif.in_instr = 32'hFFFFFFFF;
        dif.in_pc    = 32'h704;
        cur_exp      = mk(32'h704, 5'd0, 32'h0, 32'h0, 32'h0, 4'd0, 3'd7, 1'b0, 1'b1);
        step();
        dif.in_valid = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
